// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: requester count, select width, FSM state type and requester indices.
// Ports: none (package).
package mem_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam logic [SEL_W-1:0] REQ_IF  = 2'd0;
  localparam logic [SEL_W-1:0] REQ_LS  = 2'd1;
  localparam logic [SEL_W-1:0] REQ_DMA = 2'd2;
  localparam logic [SEL_W-1:0] REQ_DBG = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/memory handshake bundle for the arbiter
// Purpose: groups the request, grant, select and memory handshake signals.
// Ports (signals):
//   req_i     requester level requests        mem_ack_i memory completion pulse
//   gnt_o     one-hot grant                   sel_o     datapath mux select
//   mem_req_o memory transaction strobe       done_o    per-requester completion pulse
//   err_o     timeout abort pulse             busy_o    access in progress
// Modports: master = arbiter side, slave = requester/memory side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic               mem_ack_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [SEL_W-1:0]   sel_o;
  logic               mem_req_o;
  logic [NUM_REQ-1:0] done_o;
  logic               err_o;
  logic               busy_o;

  modport master (
    input  req_i, mem_ack_i,
    output gnt_o, sel_o, mem_req_o, done_o, err_o, busy_o
  );

  modport slave (
    output req_i, mem_ack_i,
    input  gnt_o, sel_o, mem_req_o, done_o, err_o, busy_o
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
// Purpose: picks the first requester after last_i in modulo-4 order.
// Ports:
//   req_i   request vector          last_i  most recently served index
//   valid_o any request present     idx_o   winning index
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic               valid_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [SEL_W-1:0] cand;

  // Scan from lowest priority (last itself) up to highest (last+1) so the
  // final match left standing is the highest-priority requester.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = last_i;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = last_i + SEL_W'(i);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared 16-bit memory port
// Purpose: grants one of four requesters at a time, waits for mem_ack_i and
//   aborts with err_o after TIMEOUT_CYC cycles without acknowledge.
// Ports:
//   clk_i  clock (rising edge)   rst_i  synchronous active-high reset
//   bus    master modport of mem_port_arbiter_if (requests, grant, select,
//          memory handshake, completion/error pulses, busy)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_port_arbiter_if.master bus
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               mem_req_q, mem_req_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0] eff_req;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;

  // The requester being completed this cycle still has req_i high; masking it
  // prevents an immediate back-to-back regrant of the same requester.
  assign eff_req = bus.req_i & ~done_q;

  rr_pick u_rr_pick (
    .req_i   (eff_req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    mem_req_d = mem_req_q;
    done_d    = '0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_ACCESS;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          mem_req_d       = 1'b1;
          busy_d          = 1'b1;
          cnt_d           = '0;
        end
      end
      ST_ACCESS: begin
        // An ack coinciding with the terminal count wins: normal completion.
        if (bus.mem_ack_i || (cnt_q == 8'(TIMEOUT_CYC - 1))) begin
          state_d   = ST_IDLE;
          done_d    = gnt_q;
          err_d     = ~bus.mem_ack_i;
          gnt_d     = '0;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          last_d    = sel_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= REQ_DBG;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.sel_o     = sel_q;
  assign bus.mem_req_o = mem_req_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the CPU's single 16-bit memory port among four requesters: instruction fetch, load/store, DMA and debug. It drives the 2-bit select of the existing 4:1 16-bit datapath mux that steers requester address/data onto the port. It runs one transaction at a time and waits for the memory acknowledge. If the acknowledge never arrives, it aborts the transaction after a bounded number of cycles.

## Interface
- TIMEOUT_CYC, 16, cycles a grant may wait for `mem_ack_i` before abort; legal range 2..255
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- req_i  input  4  level request per requester; bit k = requester k
- gnt_o  output  4  one-hot grant, registered
- sel_o  output  2  binary index of granted requester, driven to the datapath mux select; registered
- mem_req_o  output  1  transaction strobe to memory; high for the whole access
- mem_ack_i  input  1  memory completion, single-cycle pulse
- done_o  output  4  one-cycle completion pulse to the served requester
- err_o  output  1  one-cycle pulse, coincident with `done_o`, when the access was aborted by timeout
- busy_o  output  1  high while in ACCESS

## Operation
- States:
  - IDLE: `gnt_o`=0, `mem_req_o`=0.
  - ACCESS: exactly one bit of `gnt_o` set, `mem_req_o`=1.
- Pointer `last` (2 bits) holds the most recently served requester.
- Priority order is last+1, last+2, last+3, last, with modulo-4 wrap (3→0).
- IDLE → ACCESS:
  - Trigger: any effective request exists, where effective request = `req_i` & ~`done_o`. This masks out the requester being acknowledged this cycle.
  - On entry, register the winner into `sel_o` and `gnt_o`, and clear the timeout counter.
- ACCESS → IDLE on `mem_ack_i`:
  - Set `done_o`[winner] for one cycle, clear `gnt_o`/`mem_req_o`, and set `last` = winner.
- ACCESS → IDLE on timeout:
  - Trigger: the counter reaches TIMEOUT_CYC−1 with no ack.
  - Same actions as the ack exit, plus `err_o`=1 for that cycle.
- An ack on the same cycle as the timeout terminal count is treated as a normal ack, with `err_o`=0.
- Requesters must hold `req_i` until `done_o`. Dropping `req_i` during ACCESS is ignored: the access completes or times out normally.
- `mem_ack_i` in IDLE is ignored: no `done_o`, no state change.
- `sel_o` holds its last value in IDLE. It is meaningful only when `busy_o`=1.
- Reset values:
  - state = IDLE
  - `gnt_o` = 0, `done_o` = 0, `err_o` = 0, `mem_req_o` = 0, `busy_o` = 0
  - `sel_o` = 2'b00
  - `last` = 2'd3, so requester 0 wins first
  - counter = 0
- Reset asserted mid-ACCESS abandons the transaction: no `done_o`/`err_o` pulse, and all outputs take reset values the next edge.

## Timing
- Grant latency: `req_i` seen high at edge n (in IDLE) → `gnt_o`/`sel_o`/`mem_req_o` valid after edge n.
- Completion:
  - `mem_ack_i` high at edge m → `done_o` high and `gnt_o` low after edge m.
  - The next grant appears after edge m+1 at the earliest.
  - Minimum gap between grants is one IDLE cycle.
- Timeout: with no ack, `err_o`/`done_o` pulse appears TIMEOUT_CYC cycles after `mem_req_o` rose.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mem_arb_pkg`:
  - NUM_REQ=4, SEL_W=2
  - state enum {ST_IDLE, ST_ACCESS}
  - requester index constants REQ_IF=0, REQ_LS=1, REQ_DMA=2, REQ_DBG=3
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: 4-bit request, 2-bit `last`.
  - Outputs: valid, 2-bit index.
- Top level holds the FSM, the pointer and the timeout counter (8-bit).

## Test plan
- Reset, then `req_i`=4'b1111 held, ack 2 cycles after each grant → grants in order 0,1,2,3,0, each with `sel_o` matching; exactly one `done_o` pulse per grant.
- `req_i`=4'b0100 only, ack 1 cycle after grant → `sel_o`=2; `done_o`=4'b0100. With `req_i` still high during the `done_o` cycle, no regrant that cycle; regrant one cycle later.
- TIMEOUT_CYC=16, `req_i`=4'b0010, never ack → `err_o` and `done_o`=4'b0010 exactly 16 cycles after `mem_req_o` rose; `busy_o` low the next cycle.
- `mem_ack_i` on the terminal timeout cycle → `done_o` pulse, `err_o`=0. Separately, `mem_ack_i` pulsed in IDLE → no outputs change.
- `rst_i` asserted mid-ACCESS with requester 3 granted → next cycle all outputs zero, no `done_o`. After release with `req_i`=4'b1001, requester 0 is granted first.
- Requester drops `req_i` mid-ACCESS → grant holds until ack; `done_o` still pulses for it.
